// File: rtl/conway_pkg.sv
// rtl/conway_pkg.sv - shared rule constants, FSM states and row-wrap helper for the generation engine
package conway_pkg;

    localparam logic [3:0] BIRTH_COUNT = 4'd3;
    localparam logic [3:0] SURVIVE_MIN = 4'd2;
    localparam logic [3:0] SURVIVE_MAX = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        COMMIT
    } state_t;

    // Folds a virtual row index in [0, 2*height) back into [0, height)
    function automatic int unsigned wrap_row(input int unsigned idx, input int unsigned height);
        return (idx >= height) ? idx - height : idx;
    endfunction

endpackage

// File: rtl/conway_gen_engine_if.sv
// rtl/conway_gen_engine_if.sv - host row load/read port bundle for the generation engine
interface conway_gen_engine_if #(
    parameter int WIDTH  = 16,
    parameter int ROW_AW = 4
) ();
    logic              host_we;
    logic              host_re;
    logic [ROW_AW-1:0] host_addr;
    logic [WIDTH-1:0]  host_wdata;
    logic [WIDTH-1:0]  host_rdata;
    logic              host_rvalid;

    modport master (
        output host_we, host_re, host_addr, host_wdata,
        input  host_rdata, host_rvalid
    );

    modport slave (
        input  host_we, host_re, host_addr, host_wdata,
        output host_rdata, host_rvalid
    );
endinterface

// File: rtl/conway_cell.sv
// rtl/conway_cell.sv - single-cell life rule from the eight neighbour states
module conway_cell
    import conway_pkg::*;
(
    input  logic       alive,
    input  logic [7:0] nbrs,
    output logic       next_alive
);
    logic [3:0] sum;

    // Neighbour count; at most 8 so 4 bits never overflow
    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'b000, nbrs[i]};
        end
    end

    assign next_alive = (sum == BIRTH_COUNT) ||
                        (alive && (sum >= SURVIVE_MIN) && (sum <= SURVIVE_MAX));
endmodule

// File: rtl/conway_row.sv
// rtl/conway_row.sv - combinational next-row from a three-row window, column edges dead or toroidal
module conway_row #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] above,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] below,
    input  logic             wrap,
    output logic [WIDTH-1:0] next_row
);
    // ext[j] holds column j-1, so ext[0] is column -1 and ext[WIDTH+1] is column WIDTH
    logic [WIDTH+1:0] ext_a, ext_c, ext_b;

    assign ext_a = {wrap & above[0], above, wrap & above[WIDTH-1]};
    assign ext_c = {wrap & cur[0],   cur,   wrap & cur[WIDTH-1]};
    assign ext_b = {wrap & below[0], below, wrap & below[WIDTH-1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        conway_cell u_cell (
            .alive      (ext_c[i+1]),
            .nbrs       ({ext_a[i+2:i], ext_c[i+2], ext_c[i], ext_b[i+2:i]}),
            .next_alive (next_row[i])
        );
    end
endmodule

// File: rtl/conway_gen_engine.sv
// rtl/conway_gen_engine.sv - ping-pong row-parallel life engine; CONWAY_POP_COUNT_EN adds pop_count
module conway_gen_engine
    import conway_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int ROW_AW = 4,
    parameter int GEN_W  = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                wrap,
    output logic                busy,
    output logic                done,
    output logic [GEN_W-1:0]    gen_count,
`ifdef CONWAY_POP_COUNT_EN
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] pop_count,
`endif
    conway_gen_engine_if.slave  host
);
    localparam int                DEPTH      = 2 ** ROW_AW;
    localparam logic [ROW_AW:0]   H_L        = (ROW_AW+1)'(HEIGHT);
    localparam logic [ROW_AW:0]   TWO        = (ROW_AW+1)'(2);
    localparam logic [ROW_AW-1:0] LAST_ROW   = ROW_AW'(HEIGHT - 1);
    localparam logic [ROW_AW-1:0] PRIME_LAST = ROW_AW'(2);

    logic [WIDTH-1:0]  mem [2][DEPTH];
    state_t            state;
    logic              disp_sel;
    logic              wrap_q;
    logic [ROW_AW-1:0] cnt;
    logic [WIDTH-1:0]  above_q, cur_q, rd_q, next_row;
    logic [ROW_AW-1:0] rd_row;
    logic              rd_zero;
    logic              host_wr_ok;

    assign host_wr_ok = host.host_we && !busy && ({1'b0, host.host_addr} < H_L);

    // Window read address: PRIME fetches rows H-1, 0, 1; RUN fetches row r+2, zeroed off-grid without wrap
    always_comb begin
        rd_row  = '0;
        rd_zero = 1'b1;
        if (state == PRIME) begin
            rd_row  = ROW_AW'(wrap_row(32'(cnt) + HEIGHT - 1, HEIGHT));
            rd_zero = (cnt == '0) && !wrap_q;
        end else if (state == RUN) begin
            rd_row  = ROW_AW'(wrap_row(32'(cnt) + 2, HEIGHT));
            rd_zero = !wrap_q && (({1'b0, cnt} + TWO) >= H_L);
        end
    end

    // Host writes land in the display buffer, engine writes in the work buffer; never both in one cycle
    always_ff @(posedge clk) begin
        if (host_wr_ok)
            mem[disp_sel][host.host_addr] <= host.host_wdata;
        if (state == RUN)
            mem[~disp_sel][cnt] <= next_row;
    end

    // Registered engine read port; returns pre-write data on same-address collision
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rd_q <= '0;
        else
            rd_q <= rd_zero ? '0 : mem[disp_sel][rd_row];
    end

    // Registered host read port, always from the display buffer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            host.host_rdata  <= '0;
            host.host_rvalid <= 1'b0;
        end else begin
            host.host_rvalid <= host.host_re;
            if (host.host_re)
                host.host_rdata <= ({1'b0, host.host_addr} < H_L) ? mem[disp_sel][host.host_addr] : '0;
        end
    end

    conway_row #(.WIDTH(WIDTH)) u_row (
        .above    (above_q),
        .cur      (cur_q),
        .below    (rd_q),
        .wrap     (wrap_q),
        .next_row (next_row)
    );

    // Sequencer: IDLE -> PRIME (3 reads) -> RUN (one row per cycle) -> COMMIT (swap buffers)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            gen_count <= '0;
            disp_sel  <= 1'b0;
            wrap_q    <= 1'b0;
            cnt       <= '0;
            above_q   <= '0;
            cur_q     <= '0;
        end else begin
            done <= 1'b0;
            if (state == PRIME || state == RUN) begin
                above_q <= cur_q;
                cur_q   <= rd_q;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= PRIME;
                        busy   <= 1'b1;
                        wrap_q <= wrap;
                        cnt    <= '0;
                    end
                end
                PRIME: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == PRIME_LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ROW) begin
                        state <= COMMIT;
                        done  <= 1'b1;
                    end
                end
                COMMIT: begin
                    disp_sel  <= ~disp_sel;
                    gen_count <= gen_count + 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONWAY_POP_COUNT_EN
    localparam int PC_W = $clog2(WIDTH*HEIGHT+1);
    logic [PC_W-1:0] pop_acc, row_pop;

    // Live cells in the row being written this cycle
    always_comb begin
        row_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row_pop = row_pop + PC_W'(next_row[i]);
        end
    end

    // Accumulate over RUN, publish at COMMIT
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pop_acc   <= '0;
            pop_count <= '0;
        end else begin
            if (state == IDLE)
                pop_acc <= '0;
            else if (state == RUN)
                pop_acc <= pop_acc + row_pop;
            else if (state == COMMIT)
                pop_count <= pop_acc;
        end
    end
`endif
endmodule
